// File: rtl/dma_axi_rd_ctrl_if.sv
// rtl/dma_axi_rd_ctrl_if.sv - shared types and port bundle for the AXI read DMA back end
//
// dma_axi_rd_pkg : address/data widths, request/response structs, DMA mode enum.
// dma_axi_rd_ctrl_if:
//   streamer side : dma_axi_req, dma_axi_resp, dma_mode, dma_abort, err_clr
//   AXI AR        : arvalid, arready, araddr, arlen, arsize, arburst, arid
//   AXI R         : rvalid, rready, rdata, rresp, rlast
//   FIFO side     : rd_data, rd_valid, rd_ready
//   status        : rd_err, idle
//   modport master = the read controller, modport slave = everything around it.

`ifndef DMA_ADDR_WIDTH
`define DMA_ADDR_WIDTH 32
`endif
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 64
`endif

package dma_axi_rd_pkg;
    localparam int ADDR_W = `DMA_ADDR_WIDTH;
    localparam int DATA_W = `DMA_DATA_WIDTH;
    localparam int STRB_W = DATA_W / 8;
    localparam int ID_W   = 4;

    typedef enum logic [1:0] {
        DMA_MODE_INCR  = 2'd0,
        DMA_MODE_FIXED = 2'd1,
        DMA_MODE_WRAP  = 2'd2
    } dma_mode_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        alen;
        logic [2:0]        size;
        logic [STRB_W-1:0] strb;
    } s_dma_axi_req_t;

    typedef struct packed {
        logic ready;
        logic err;
    } s_dma_axi_resp_t;
endpackage

interface dma_axi_rd_ctrl_if;
    import dma_axi_rd_pkg::*;

    s_dma_axi_req_t    dma_axi_req;
    s_dma_axi_resp_t   dma_axi_resp;
    dma_mode_t         dma_mode;
    logic              dma_abort;
    logic              err_clr;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [ID_W-1:0]   arid;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              rd_err;
    logic              idle;

    modport master (
        input  dma_axi_req, dma_mode, dma_abort, err_clr,
        input  arready, rvalid, rdata, rresp, rlast, rd_ready,
        output dma_axi_resp, arvalid, araddr, arlen, arsize, arburst, arid,
        output rready, rd_data, rd_valid, rd_err, idle
    );

    modport slave (
        output dma_axi_req, dma_mode, dma_abort, err_clr,
        output arready, rvalid, rdata, rresp, rlast, rd_ready,
        input  dma_axi_resp, arvalid, araddr, arlen, arsize, arburst, arid,
        input  rready, rd_data, rd_valid, rd_err, idle
    );
endinterface

// File: rtl/dma_axi_rd_ctrl.sv
// rtl/dma_axi_rd_ctrl.sv - AXI4 read-master back end for the read DMA streamer
//
// Accepts one streamer request at a time, issues it on AR (single fixed ID),
// tracks up to MAX_OUTSTANDING bursts in a small burst FIFO, counts R beats
// against ARLEN, forwards beats to the DMA FIFO and flags protocol errors.
// Abort stops new requests and drains (accepts and discards) outstanding data.
//
// Ports: clk, rst (synchronous, active high), bus (dma_axi_rd_ctrl_if.master).
// Optional feature macro DMA_RD_STRB_MASK_EN: store req.strb per burst and zero
// disabled bytes of every beat of that burst.

module dma_axi_rd_ctrl
    import dma_axi_rd_pkg::*;
#(
    parameter int              MAX_OUTSTANDING = 4,
    parameter logic [ID_W-1:0] AXI_ID          = '0
) (
    input  logic               clk,
    input  logic               rst,
    dma_axi_rd_ctrl_if.master  bus
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {ST_RUN, ST_DRAIN} state_t;
    state_t state_q, state_d;

    logic              init_q;
    logic              arvalid_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [7:0]        arlen_q;
    logic [2:0]        arsize_q;
    logic [1:0]        arburst_q;
    logic [CNT_W-1:0]  os_cnt_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [8:0]        beat_cnt_q;
    logic              rd_err_q;
    logic [7:0]        alen_mem [MAX_OUTSTANDING];

    logic ready, accept, ar_hs, r_hs, fifo_empty, beat_last, pop, err_set;
    logic idle, abort_drain;

    assign idle       = ~arvalid_q & (os_cnt_q == '0);
    assign fifo_empty = (os_cnt_q == '0);
    // init_q keeps ready low for the first cycle out of reset.
    assign ready      = ~arvalid_q & (os_cnt_q < CNT_W'(MAX_OUTSTANDING)) & ~bus.dma_abort
                        & ~abort_drain & ~init_q & ~rst;
    assign accept     = bus.dma_axi_req.valid & ready;
    assign ar_hs      = arvalid_q & bus.arready;
    assign r_hs       = bus.rvalid & bus.rready;
    assign beat_last  = ({1'b0, alen_mem[rd_ptr_q]} == beat_cnt_q);
    // The burst is closed by ARLEN, not RLAST, so a bad RLAST cannot desync the FIFO.
    assign pop        = r_hs & ~fifo_empty & beat_last;
    assign err_set    = r_hs & (fifo_empty | (bus.rlast != beat_last) | (bus.rresp != 2'b00));

    always_comb begin
        state_d     = state_q;
        abort_drain = 1'b0;
        case (state_q)
            ST_RUN:   if (bus.dma_abort && !idle) state_d = ST_DRAIN;
            ST_DRAIN: begin
                abort_drain = 1'b1;
                if (idle) state_d = ST_RUN;
            end
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            init_q     <= 1'b1;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arsize_q   <= '0;
            arburst_q  <= '0;
            os_cnt_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            beat_cnt_q <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b0;
            if (accept) begin
                arvalid_q <= 1'b1;
                araddr_q  <= bus.dma_axi_req.addr;
                arlen_q   <= bus.dma_axi_req.alen;
                arsize_q  <= bus.dma_axi_req.size;
                arburst_q <= (bus.dma_mode == DMA_MODE_FIXED) ? 2'b00 : 2'b01;
            end else if (ar_hs) begin
                arvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (r_hs && !fifo_empty) begin
                beat_cnt_q <= beat_last ? '0 : beat_cnt_q + 9'd1;
            end
            case ({ar_hs, pop})
                2'b10:   os_cnt_q <= os_cnt_q + CNT_W'(1);
                2'b01:   os_cnt_q <= os_cnt_q - CNT_W'(1);
                default: os_cnt_q <= os_cnt_q;
            endcase
            rd_err_q <= err_set | (rd_err_q & ~bus.err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (ar_hs) alen_mem[wr_ptr_q] <= arlen_q;
    end

`ifdef DMA_RD_STRB_MASK_EN
    logic [STRB_W-1:0] strb_q;
    logic [STRB_W-1:0] strb_mem [MAX_OUTSTANDING];
    logic [STRB_W-1:0] head_strb;
    logic [DATA_W-1:0] rd_data_m;

    always_ff @(posedge clk) begin
        if (rst) strb_q <= '0;
        else if (accept) strb_q <= bus.dma_axi_req.strb;
    end

    always_ff @(posedge clk) begin
        if (ar_hs) strb_mem[wr_ptr_q] <= strb_q;
    end

    assign head_strb = strb_mem[rd_ptr_q];
    for (genvar g = 0; g < STRB_W; g++) begin : g_mask
        assign rd_data_m[g*8 +: 8] = bus.rdata[g*8 +: 8] & {8{head_strb[g]}};
    end
    assign bus.rd_data = rd_data_m;
`else
    logic unused_strb;
    assign unused_strb = ^bus.dma_axi_req.strb;
    assign bus.rd_data = bus.rdata;
`endif

    assign bus.arvalid      = arvalid_q;
    assign bus.araddr       = araddr_q;
    assign bus.arlen        = arlen_q;
    assign bus.arsize       = arsize_q;
    assign bus.arburst      = arburst_q;
    assign bus.arid         = AXI_ID;
    assign bus.rready       = bus.rd_ready | abort_drain;
    assign bus.rd_valid     = bus.rvalid & ~abort_drain;
    assign bus.rd_err       = rd_err_q;
    assign bus.idle         = idle;
    assign bus.dma_axi_resp = '{ready: ready, err: 1'b0};
endmodule

// File: tb/tb_dma_axi_rd_ctrl.sv
// tb/tb_dma_axi_rd_ctrl.sv - self-checking bench for dma_axi_rd_ctrl

`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert (64'(obs) === 64'(exp)) else begin \
            errors++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, 64'(obs), 64'(exp)); \
        end \
    end

module tb_dma_axi_rd_ctrl;
    import dma_axi_rd_pkg::*;

    localparam int MAX_OS = 4;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  alen;
        logic [7:0]  strb;
        dma_mode_t   mode;
    } req_rec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n_acc, n_ar;

    dma_axi_rd_ctrl_if bus();

    dma_axi_rd_ctrl #(.MAX_OUTSTANDING(MAX_OS), .AXI_ID(4'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] exp_data(input logic [63:0] d, input logic [7:0] s);
        logic [63:0] r;
        r = d;
`ifdef DMA_RD_STRB_MASK_EN
        r = '0;
        for (int i = 0; i < 8; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
`else
        if (s == 8'h00) r = d;
`endif
        return r;
    endfunction

    task automatic send_req(input logic [31:0] addr, input logic [7:0] alen,
                            input logic [7:0] strb, input dma_mode_t mode);
        bit done = 0;
        bus.dma_axi_req.valid = 1'b1;
        bus.dma_axi_req.addr  = addr;
        bus.dma_axi_req.alen  = alen;
        bus.dma_axi_req.size  = 3'd3;
        bus.dma_axi_req.strb  = strb;
        bus.dma_mode          = mode;
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            if (bus.dma_axi_resp.ready === 1'b1) done = 1;
            @(negedge clk);
        end
        bus.dma_axi_req.valid = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $error("FAIL req_accepted: wait for ready expired (addr=%0h)", addr);
        end
    endtask

    task automatic ar_expect(input logic [31:0] addr, input logic [7:0] alen, input logic [1:0] burst);
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            #1;
            if (bus.arvalid === 1'b1 && bus.arready === 1'b1) begin
                seen = 1;
                `CHK("araddr", bus.araddr, addr)
                `CHK("arlen", bus.arlen, alen)
                `CHK("arburst", bus.arburst, burst)
                `CHK("arsize", bus.arsize, 3'd3)
                `CHK("arid", bus.arid, 4'h0)
                `CHK("ready_low_during_ar", bus.dma_axi_resp.ready, 1'b0)
            end
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $error("FAIL ar_seen: wait for AR handshake expired (addr=%0h)", addr);
        end
    endtask

    task automatic beats(input int n, input int last_at, input int bad_resp_at,
                         input logic [7:0] strb, input bit expect_fwd);
        for (int k = 0; k < n; k++) begin
            logic [63:0] d;
            bit took;
            d    = {$urandom, $urandom};
            took = 0;
            bus.rvalid = 1'b1;
            bus.rdata  = d;
            bus.rlast  = (k == last_at);
            bus.rresp  = (k == bad_resp_at) ? 2'b10 : 2'b00;
            for (int w = 0; w < 50 && !took; w++) begin
                #1;
                if (bus.rready === 1'b1) begin
                    took = 1;
                    `CHK("rd_valid", bus.rd_valid, expect_fwd)
                    if (expect_fwd) `CHK("rd_data", bus.rd_data, exp_data(d, strb))
                end
                @(negedge clk);
            end
            checks++;
            if (took !== 1'b1) begin
                errors++;
                $error("FAIL beat_taken: wait for rready expired (beat %0d)", k);
            end
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'b00;
    endtask

    task automatic pump(input int cycles, input int target);
        for (int c = 0; c < cycles; c++) begin
            bus.dma_axi_req.valid = (n_acc < target);
            bus.dma_axi_req.addr  = 32'h2000 + 32'(n_acc) * 32'h100;
            bus.dma_axi_req.alen  = 8'd0;
            bus.dma_mode          = DMA_MODE_INCR;
            #1;
            if (bus.arvalid === 1'b1 && bus.arready === 1'b1) begin
                `CHK("bb_araddr", bus.araddr, 32'h2000 + 32'(n_ar) * 32'h100)
                n_ar++;
            end
            if (bus.dma_axi_req.valid && bus.dma_axi_resp.ready === 1'b1) n_acc++;
            @(negedge clk);
        end
    endtask

    initial begin
        req_rec_t    sent_q[$];
        req_rec_t    slave_q[$];
        req_rec_t    pend;
        logic [63:0] strb_exp;
        int          n_sent, n_done, beat_idx, os;
        bit          ar_pending;
        bit          req_fire, beat_fire;
        localparam int N_RND = 40;

        rst = 1'b1;
        bus.dma_axi_req = '0;
        bus.dma_mode    = DMA_MODE_INCR;
        bus.dma_abort   = 1'b0;
        bus.err_clr     = 1'b0;
        bus.arready     = 1'b1;
        bus.rvalid      = 1'b0;
        bus.rdata       = '0;
        bus.rresp       = 2'b00;
        bus.rlast       = 1'b0;
        bus.rd_ready    = 1'b0;
        n_acc = 0;
        n_ar  = 0;

        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.arvalid !== 1'b0) begin
            errors++;
            $error("FAIL rst_arvalid observed=%0b expected=0", bus.arvalid);
        end
        checks++;
        if (bus.rready !== 1'b0) begin
            errors++;
            $error("FAIL rst_rready observed=%0b expected=0", bus.rready);
        end
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++;
            $error("FAIL rst_rd_valid observed=%0b expected=0", bus.rd_valid);
        end
        checks++;
        if (bus.rd_err !== 1'b0) begin
            errors++;
            $error("FAIL rst_rd_err observed=%0b expected=0", bus.rd_err);
        end
        checks++;
        if (bus.idle !== 1'b1) begin
            errors++;
            $error("FAIL rst_idle observed=%0b expected=1", bus.idle);
        end
        checks++;
        if (bus.dma_axi_resp.ready !== 1'b0) begin
            errors++;
            $error("FAIL rst_ready observed=%0b expected=0", bus.dma_axi_resp.ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        `CHK("first_cycle_ready", bus.dma_axi_resp.ready, 1'b0)
        @(negedge clk);
        #1;
        `CHK("ready_after_init", bus.dma_axi_resp.ready, 1'b1)
        @(negedge clk);

        bus.rd_ready = 1'b1;
        send_req(32'h1000, 8'd15, 8'hFF, DMA_MODE_INCR);
        ar_expect(32'h1000, 8'd15, 2'b01);
        beats(16, 15, -1, 8'hFF, 1'b1);
        #1;
        `CHK("t1_idle", bus.idle, 1'b1)
        `CHK("t1_err", bus.rd_err, 1'b0)
        @(negedge clk);

        bus.rd_ready = 1'b0;
        pump(30, 5);
        #1;
        `CHK("bb_ar_count4", n_ar, 4)
        `CHK("bb_acc_count4", n_acc, 4)
        `CHK("bb_ready_low", bus.dma_axi_resp.ready, 1'b0)
        `CHK("bb_not_idle", bus.idle, 1'b0)
        @(negedge clk);
        bus.dma_axi_req.valid = 1'b0;
        bus.rd_ready = 1'b1;
        beats(1, 0, -1, 8'hFF, 1'b1);
        pump(20, 5);
        bus.dma_axi_req.valid = 1'b0;
        `CHK("bb_ar_count5", n_ar, 5)
        for (int b = 0; b < 4; b++) beats(1, 0, -1, 8'hFF, 1'b1);
        #1;
        `CHK("bb_idle", bus.idle, 1'b1)
        @(negedge clk);

        send_req(32'h3000, 8'd3, 8'hFF, DMA_MODE_INCR);
        ar_expect(32'h3000, 8'd3, 2'b01);
        beats(4, 1, -1, 8'hFF, 1'b1);
        #1;
        `CHK("rlast_err", bus.rd_err, 1'b1)
        `CHK("rlast_idle", bus.idle, 1'b1)
        repeat (3) @(negedge clk);
        #1;
        `CHK("err_sticky", bus.rd_err, 1'b1)
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        #1;
        `CHK("err_cleared", bus.rd_err, 1'b0)
        @(negedge clk);
        send_req(32'h3100, 8'd1, 8'hFF, DMA_MODE_FIXED);
        ar_expect(32'h3100, 8'd1, 2'b00);
        beats(2, 1, -1, 8'hFF, 1'b1);
        #1;
        `CHK("clean_err", bus.rd_err, 1'b0)
        @(negedge clk);

        send_req(32'h4000, 8'd0, 8'hFF, DMA_MODE_WRAP);
        ar_expect(32'h4000, 8'd0, 2'b01);
        beats(1, 0, 0, 8'hFF, 1'b1);
        #1;
        `CHK("rresp_err", bus.rd_err, 1'b1)
        `CHK("rresp_idle", bus.idle, 1'b1)
        @(negedge clk);

        bus.rvalid  = 1'b1;
        bus.rlast   = 1'b1;
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.rvalid  = 1'b0;
        bus.rlast   = 1'b0;
        bus.err_clr = 1'b0;
        #1;
        `CHK("unexp_err_wins", bus.rd_err, 1'b1)
        `CHK("unexp_idle", bus.idle, 1'b1)
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        #1;
        `CHK("unexp_cleared", bus.rd_err, 1'b0)
        @(negedge clk);

        send_req(32'h5000, 8'd1, 8'hFF, DMA_MODE_INCR);
        ar_expect(32'h5000, 8'd1, 2'b01);
        send_req(32'h5100, 8'd1, 8'hFF, DMA_MODE_INCR);
        ar_expect(32'h5100, 8'd1, 2'b01);
        bus.rd_ready  = 1'b0;
        bus.dma_abort = 1'b1;
        #1;
        `CHK("abort_ready", bus.dma_axi_resp.ready, 1'b0)
        @(negedge clk);
        bus.dma_abort = 1'b0;
        #1;
        `CHK("drain_rready", bus.rready, 1'b1)
        `CHK("drain_ready", bus.dma_axi_resp.ready, 1'b0)
        @(negedge clk);
        beats(2, 1, -1, 8'hFF, 1'b0);
        beats(2, 1, -1, 8'hFF, 1'b0);
        #1;
        `CHK("drain_idle", bus.idle, 1'b1)
        `CHK("drain_err", bus.rd_err, 1'b0)
        repeat (2) @(negedge clk);
        #1;
        `CHK("after_drain_ready", bus.dma_axi_resp.ready, 1'b1)
        @(negedge clk);

        bus.rd_ready = 1'b1;
        send_req(32'h6000, 8'd0, 8'hF8, DMA_MODE_INCR);
        ar_expect(32'h6000, 8'd0, 2'b01);
`ifdef DMA_RD_STRB_MASK_EN
        strb_exp = 64'h1122334455000000;
`else
        strb_exp = 64'h1122334455667788;
`endif
        bus.rvalid = 1'b1;
        bus.rdata  = 64'h1122334455667788;
        bus.rlast  = 1'b1;
        #1;
        `CHK("strb_data", bus.rd_data, strb_exp)
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        #1;
        `CHK("strb_idle", bus.idle, 1'b1)
        @(negedge clk);

        n_sent = 0; n_done = 0; beat_idx = 0; os = 0; ar_pending = 0;
        pend = '{addr: 32'h0, alen: 8'h0, strb: 8'h0, mode: DMA_MODE_INCR};
        for (int c = 0; c < 5000 && n_done < N_RND; c++) begin
            if (!bus.dma_axi_req.valid && n_sent < N_RND && $urandom_range(0, 1) == 1) begin
                pend.addr = $urandom & 32'hFFFF_FFC0;
                pend.alen = 8'($urandom_range(0, 7));
                pend.strb = 8'($urandom);
                pend.mode = dma_mode_t'($urandom_range(0, 2));
                bus.dma_axi_req.valid = 1'b1;
                bus.dma_axi_req.addr  = pend.addr;
                bus.dma_axi_req.alen  = pend.alen;
                bus.dma_axi_req.strb  = pend.strb;
                bus.dma_mode          = pend.mode;
            end
            bus.arready = 1'($urandom_range(0, 1));
            if (!bus.rvalid && slave_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                bus.rvalid = 1'b1;
                bus.rdata  = {$urandom, $urandom};
                bus.rlast  = (beat_idx == int'(slave_q[0].alen));
                bus.rresp  = 2'b00;
            end
            bus.rd_ready = ($urandom_range(0, 3) != 0);
            #1;
            `CHK("rnd_ready", bus.dma_axi_resp.ready, (!ar_pending && os < MAX_OS))
            `CHK("rnd_idle", bus.idle, (!ar_pending && os == 0))
            `CHK("rnd_rready", bus.rready, bus.rd_ready)
            if (bus.rvalid) begin
                `CHK("rnd_rd_valid", bus.rd_valid, 1'b1)
                `CHK("rnd_rd_data", bus.rd_data, exp_data(bus.rdata, slave_q[0].strb))
            end
            req_fire  = 0;
            beat_fire = 0;
            if (bus.arvalid === 1'b1 && bus.arready) begin
                `CHK("rnd_araddr", bus.araddr, sent_q[0].addr)
                `CHK("rnd_arlen", bus.arlen, sent_q[0].alen)
                `CHK("rnd_arburst", bus.arburst, (sent_q[0].mode == DMA_MODE_FIXED) ? 2'b00 : 2'b01)
                slave_q.push_back(sent_q.pop_front());
                ar_pending = 0;
                os++;
            end
            if (bus.dma_axi_req.valid && bus.dma_axi_resp.ready === 1'b1) begin
                sent_q.push_back(pend);
                ar_pending = 1;
                n_sent++;
                req_fire = 1;
            end
            if (bus.rvalid && bus.rready === 1'b1) begin
                beat_fire = 1;
                if (beat_idx == int'(slave_q[0].alen)) begin
                    void'(slave_q.pop_front());
                    beat_idx = 0;
                    os--;
                    n_done++;
                end else begin
                    beat_idx++;
                end
            end
            @(negedge clk);
            if (req_fire) bus.dma_axi_req.valid = 1'b0;
            if (beat_fire) begin
                bus.rvalid = 1'b0;
                bus.rlast  = 1'b0;
            end
        end
        #1;
        `CHK("rnd_all_done", n_done, N_RND)
        `CHK("rnd_err", bus.rd_err, 1'b0)
        `CHK("rnd_final_idle", bus.idle, 1'b1)

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
